uart_tx_framed: RTL and testbench

// - Parametrised UART transmitter; next generation of the team's fixed 8-bit, even-parity, 1-stop TX.
// - Adds runtime frame format: data width, parity none/even/odd, 1 or 2 stop bits.
// - Adds a valid/ready input handshake and an optional TX FIFO.
// - Sits between the system-side byte producer and the TxD pad; the 16x baud tick is generated internally.

---
 rtl/uart_tx_pkg.sv | 34 +++
 rtl/uart_baud_gen.sv | 43 ++++
 rtl/uart_tx_framed.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_framed.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types, parity codes and baud-rate table for the framed UART TX.
// Rate index 0..7 maps to 300..115200 baud at 16x oversampling.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int OVERSAMPLE = 16;

  localparam int RATE_TAB [8] = '{
    300, 1200, 4800, 9600,
    19200, 38400, 57600, 115200
  };

  // Clocks per oversample tick, rounded to nearest.
  function automatic int baud_div(
    input int         clk_hz,
    input logic [2:0] idx
  );
    int den;
    den = OVERSAMPLE * RATE_TAB[idx];
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversample tick generator for the framed UART TX.
// Emits a one-cycle tick every baud_div(CLK_HZ, baud_select) clocks.
module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       clear,
  output logic       tick
);

  localparam int CNT_W = $clog2(baud_div(CLK_HZ, 3'd0));

  logic [CNT_W-1:0] div_tab [8];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  for (genvar i = 0; i < 8; i++) begin : g_div
    assign div_tab[i] =
      CNT_W'(baud_div(CLK_HZ, 3'(i)) - 1);
  end

  assign tick = (cnt_q == div_tab[baud_select]);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: runtime width/parity/stop format, valid/ready.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO and fifo_level.
module uart_tx_framed
  import uart_tx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic [2:0]        baud_select,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              tx_busy
`ifdef UART_TX_FIFO_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`endif
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST = BIT_W'(DATA_W - 1);

  if (DATA_W < 5 || DATA_W > 9 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_framed: illegal DATA_W or FIFO_DEPTH");
  end

  state_e            state_q;
  logic [DATA_W-1:0] sh_q;
  logic [BIT_W-1:0]  bit_q;
  logic [3:0]        os_q;
  logic [2:0]        baud_q;
  logic              par_q;
  logic              par_en_q;
  logic              stop2_q;
  logic              txd_q;
  logic              busy_q;
  logic              run_q;

  logic              load;
  logic [DATA_W-1:0] ld_data;
  logic              tick;
  logic              bit_end;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_q;
  logic [AW:0]       rd_q;
  logic              full;
  logic              empty;
  logic              push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign tx_ready   = run_q & ~full;
  assign push       = tx_valid & tx_ready;
  assign load       = run_q & tx_en & ~empty & (state_q == IDLE);
  assign ld_data    = mem_q[rd_q[AW-1:0]];
  assign fifo_level = wr_q - rd_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (load) rd_q <= rd_q + 1'b1;
    end
  end
`else
  assign tx_ready = run_q & tx_en & (state_q == IDLE);
  assign load     = tx_valid & tx_ready;
  assign ld_data  = tx_data;
`endif

  uart_baud_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_baud (
    .clk        (clk),
    .reset      (reset),
    .baud_select(baud_q),
    .clear      (load),
    .tick       (tick)
  );

  assign bit_end = tick && (os_q == 4'(OVERSAMPLE - 1));
  assign txd     = txd_q;
  assign tx_busy = busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      bit_q    <= '0;
      os_q     <= '0;
      baud_q   <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (tick) os_q <= os_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            sh_q     <= ld_data;
            par_en_q <= (parity_mode == PAR_EVEN) ||
                        (parity_mode == PAR_ODD);
            par_q    <= (parity_mode == PAR_ODD) ?
                        ~^ld_data : ^ld_data;
            stop2_q  <= stop2;
            baud_q   <= baud_select;
            os_q     <= '0;
            bit_q    <= '0;
            txd_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            txd_q   <= sh_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            sh_q  <= sh_q >> 1;
            bit_q <= bit_q + 1'b1;
            if (bit_q == LAST) begin
              bit_q   <= '0;
              txd_q   <= par_en_q ? par_q : 1'b1;
              state_q <= par_en_q ? PARITY : STOP;
            end else begin
              txd_q <= sh_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            txd_q   <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop2_q && bit_q == '0) begin
              bit_q <= 1'b1;
            end else begin
              bit_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench for uart_tx_framed (table frames + corner sequences).
// FIFO sequence is compiled only when UART_TX_FIFO_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_framed;
  import uart_tx_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx_en = 1'b0;
  logic          stop2 = 1'b0;
  logic          tx_valid = 1'b0;
  logic [2:0]    baud_select = 3'd7;
  logic [1:0]    parity_mode = PAR_NONE;
  logic [DW-1:0] tx_data = '0;
  logic          tx_ready;
  logic          txd;
  logic          tx_busy;
`ifdef UART_TX_FIFO_EN
  logic [2:0]    fifo_level;
`endif

  typedef struct {
    logic [7:0] data;
    logic [1:0] pm;
    logic       s2;
    logic [2:0] bsel;
    int         div;
    bit         par;
    int         len;
  } vec_t;

  vec_t tbl [5];
  vec_t nxt;
  int   errs = 0;
  int   checks = 0;
  bit   exp_q [$];

  always #5 clk = ~clk;

  uart_tx_framed #(
    .CLK_HZ    (50_000_000),
    .DATA_W    (DW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_en      (tx_en),
    .baud_select(baud_select),
    .parity_mode(parity_mode),
    .stop2      (stop2),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .tx_busy    (tx_busy)
`ifdef UART_TX_FIFO_EN
    ,
    .fifo_level (fifo_level)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic xfer(vec_t v);
    int n;
    @(negedge clk);
    tx_data     = v.data;
    parity_mode = v.pm;
    stop2       = v.s2;
    baud_select = v.bsel;
    tx_en       = 1'b1;
    tx_valid    = 1'b1;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(v.data[i]);
    if (v.pm == PAR_EVEN || v.pm == PAR_ODD) exp_q.push_back(v.par);
    exp_q.push_back(1'b1);
    if (v.s2) exp_q.push_back(1'b1);
    n = 0;
    #1;
    while (!tx_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("ready timeout", 32'(tx_ready), 1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic watch(string tag, vec_t v);
    int n;
    int busy;
    int bitc;
    bit e;
    bitc = 16 * v.div;
    busy = 0;
    n = 0;
    @(negedge clk);
    while (!tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk({tag, " start timeout"}, 32'(tx_busy), 1);
      exp_q.delete();
      return;
    end
    for (int c = 0; c <= v.len; c++) begin
      if (c > 0) @(negedge clk);
      if (c < v.len) begin
        if (tx_busy) busy++;
        if (c % bitc == 2 && exp_q.size() > 0) begin
          chk($sformatf("%s bit%0d early", tag, c / bitc),
              32'(txd), 32'(exp_q[0]));
        end
        if (c % bitc == bitc - 2) begin
          if (exp_q.size() == 0) begin
            chk({tag, " extra bit"}, 32'(txd), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s bit%0d late", tag, c / bitc),
                32'(txd), 32'(e));
          end
        end
      end
    end
    chk({tag, " busy clks"}, busy, v.len);
    chk({tag, " end txd"}, 32'(txd), 1);
    chk({tag, " end busy"}, 32'(tx_busy), 0);
    chk({tag, " bits left"}, exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int bad;
`ifdef UART_TX_FIFO_EN
    int acc;
    int frames;
    int gap;
    bit rdy6;
    bit prev;
`endif
    tbl[0] = '{8'hA5, PAR_EVEN, 1'b0, 3'd7, 27, 1'b0, 4752};
    tbl[1] = '{8'h00, PAR_ODD,  1'b1, 3'd7, 27, 1'b1, 5184};
    tbl[2] = '{8'h3C, PAR_NONE, 1'b0, 3'd7, 27, 1'b0, 4320};
    tbl[3] = '{8'hFF, 2'b11,    1'b1, 3'd7, 27, 1'b0, 4752};
    tbl[4] = '{8'h7E, PAR_EVEN, 1'b1, 3'd7, 27, 1'b0, 5184};
    nxt    = '{8'h81, PAR_ODD,  1'b1, 3'd6, 54, 1'b1, 10368};

    // Reset state, with a producer already offering data.
    repeat (3) @(negedge clk);
    tx_en    = 1'b1;
    tx_valid = 1'b1;
    #1;
    chk("reset txd", 32'(txd), 1);
    chk("reset busy", 32'(tx_busy), 0);
    chk("reset ready", 32'(tx_ready), 0);
    @(negedge clk);
    reset    = 1'b1;
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      xfer(tbl[i]);
      watch($sformatf("vec%0d", i), tbl[i]);
    end

    // Abort during DATA bit 3, then a clean frame.
    xfer(tbl[0]);
    n = 0;
    @(negedge clk);
    while (!tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4 * 432 + 200) @(negedge clk);
    chk("pre-abort txd", 32'(txd), 0);
    reset = 1'b0;
    #1;
    chk("abort txd", 32'(txd), 1);
    chk("abort busy", 32'(tx_busy), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    xfer(tbl[0]);
    watch("post-abort", tbl[0]);

    // Config and tx_en changes mid-frame must not disturb it.
    xfer(tbl[0]);
    fork
      begin
        repeat (2000) @(negedge clk);
        parity_mode = PAR_ODD;
        stop2       = 1'b1;
        baud_select = 3'd6;
        tx_data     = 8'h81;
        tx_en       = 1'b0;
        tx_valid    = 1'b1;
      end
    join_none
    watch("cfg-hold", tbl[0]);

    // Disabled transmitter with a pending offer.
    tx_en    = 1'b0;
    tx_valid = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
`ifndef UART_TX_FIFO_EN
      if (tx_ready !== 1'b0) bad++;
`endif
    end
    chk("disabled bad clks", bad, 0);
    pulse_reset();

    xfer(nxt);
    watch("new-cfg", nxt);

`ifdef UART_TX_FIFO_EN
    pulse_reset();
    parity_mode = PAR_EVEN;
    stop2       = 1'b0;
    baud_select = 3'd7;
    tx_en       = 1'b1;
    acc  = 0;
    rdy6 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tx_data  = 8'(k + 1);
      tx_valid = 1'b1;
      #1;
      if (tx_ready) acc++;
      if (k == 5) rdy6 = tx_ready;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    chk("fifo accepted", acc, 5);
    chk("fifo ready 6th", 32'(rdy6), 0);
    frames = 0;
    gap    = 0;
    prev   = tx_busy;
    if (tx_busy) frames = 1;
    for (int c = 0; c < 5 * 4752 + 100; c++) begin
      @(negedge clk);
      if (tx_busy && !prev) begin
        frames++;
        if (frames > 1) chk($sformatf("fifo gap%0d", frames), gap, 1);
        if (frames == 5) chk("fifo level", 32'(fifo_level), 0);
        gap = 0;
      end
      if (!tx_busy) gap++;
      prev = tx_busy;
    end
    chk("fifo frames", frames, 5);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
